sna_resp_arbiter: RTL and testbench

SNA_RESP_ARBITER -- requirements
Module: sna_resp_arbiter

---
 rtl/sna_resp_arbiter_if.sv | 59 +++++
 rtl/sna_resp_arbiter.sv | 163 ++++++++++++++++
 tb/tb_sna_resp_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sna_resp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sna_resp_arbiter_if
// Purpose  : Bundles the read/write response handshakes, VC status vectors
//            and the router-side flit port of sna_resp_arbiter.
// Ports    : (interface signals)
//   rvalid, r_header, r_tail  -> read-response packet offered
//   rready                    <- one-cycle accept pulse for read response
//   bvalid, b_header, b_tail  -> write-response packet offered
//   bready                    <- one-cycle accept pulse for write response
//   is_allocatable            -> per-VC "free for a new packet"
//   is_on_off                 -> per-VC "downstream accepts a flit"
//   noc_data, is_valid        <- flit to router and its qualifier
//   vc_sel                    <- one-hot VC of the packet in flight
//   busy                      <- arbiter is not idle
// Modports : master = response sources / router side, slave = arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sna_resp_arbiter_if #(
  parameter int FLIT_W = 37,
  parameter int NUM_VC = 8
);
  logic              rvalid;
  logic [FLIT_W-1:0] r_header;
  logic [FLIT_W-1:0] r_tail;
  logic              rready;

  logic              bvalid;
  logic [FLIT_W-1:0] b_header;
  logic [FLIT_W-1:0] b_tail;
  logic              bready;

  logic [NUM_VC-1:0] is_allocatable;
  logic [NUM_VC-1:0] is_on_off;

  logic [FLIT_W-1:0] noc_data;
  logic              is_valid;
  logic [NUM_VC-1:0] vc_sel;
  logic              busy;

  modport master (
    output rvalid, r_header, r_tail,
    input  rready,
    output bvalid, b_header, b_tail,
    input  bready,
    output is_allocatable, is_on_off,
    input  noc_data, is_valid, vc_sel, busy
  );

  modport slave (
    input  rvalid, r_header, r_tail,
    output rready,
    input  bvalid, b_header, b_tail,
    output bready,
    input  is_allocatable, is_on_off,
    output noc_data, is_valid, vc_sel, busy
  );
endinterface
`default_nettype wire

// File: rtl/sna_resp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sna_resp_arbiter
// Purpose  : Round-robin arbiter between the read-response and write-response
//            channels. The winning packet (header + tail flit) is accepted
//            with a one-cycle ready pulse, locked to the lowest free VC and
//            sent to the NoC router one flit at a time, honouring the per-VC
//            on/off flow control.
// Ports    :
//   clock   in  single clock, rising edge
//   resetn  in  synchronous active-low reset
//   bus     slave modport of sna_resp_arbiter_if (handshakes, VC status,
//           flit output, vc_sel, busy)
// Revision : 1.0 - initial release
// ============================================================================
module sna_resp_arbiter #(
  parameter int FLIT_W = 37,
  parameter int NUM_VC = 8
) (
  input  wire logic         clock,
  input  wire logic         resetn,
  sna_resp_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_HEAD   = 2'd2,
    ST_TAIL   = 2'd3
  } state_t;

  state_t            state_q;
  logic              rready_q;
  logic              bready_q;
  logic              is_valid_q;
  logic              busy_q;
  logic [FLIT_W-1:0] noc_data_q;
  logic [NUM_VC-1:0] vc_sel_q;
  logic [FLIT_W-1:0] head_q;
  logic [FLIT_W-1:0] tail_q;
  logic              grant_b_q;   // channel granted in the current packet: 1 = B
  logic              last_b_q;    // channel of the last completed accept: 1 = B

  logic              req_d;
  logic              grant_b_d;
  logic [NUM_VC-1:0] vc_lock_d;
  logic              grant_valid;
  logic              vc_open;

  // Lowest-index free VC as a one-hot vector. Scanning from the top down
  // lets the lowest set bit overwrite any higher one.
  always_comb begin
    vc_lock_d = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (bus.is_allocatable[i]) begin
        vc_lock_d    = '0;
        vc_lock_d[i] = 1'b1;
      end
    end
  end

  // A request needs a packet on either channel and at least one free VC.
  assign req_d = (bus.rvalid | bus.bvalid) & (|bus.is_allocatable);

  // B wins when it is alone, or on a tie when R was the last channel served.
  assign grant_b_d = bus.bvalid & (~bus.rvalid | ~last_b_q);

  // The granted source must still be offering its packet during ACCEPT.
  assign grant_valid = grant_b_q ? bus.bvalid : bus.rvalid;

  // Flow control is only ever looked at for the locked VC.
  assign vc_open = |(bus.is_on_off & vc_sel_q);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      rready_q   <= 1'b0;
      bready_q   <= 1'b0;
      is_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      noc_data_q <= '0;
      vc_sel_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      grant_b_q  <= 1'b0;
      last_b_q   <= 1'b1;   // so that R wins the first tie
    end else begin
      // Ready and flit-valid are single-cycle pulses unless re-asserted below.
      rready_q   <= 1'b0;
      bready_q   <= 1'b0;
      is_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req_d) begin
            state_q   <= ST_ACCEPT;
            grant_b_q <= grant_b_d;
            rready_q  <= ~grant_b_d;
            bready_q  <= grant_b_d;
            vc_sel_q  <= vc_lock_d;
            busy_q    <= 1'b1;
          end else begin
            // Also clears the VC held through the previous tail cycle.
            vc_sel_q <= '0;
            busy_q   <= 1'b0;
          end
        end

        ST_ACCEPT: begin
          if (grant_valid) begin
            head_q   <= grant_b_q ? bus.b_header : bus.r_header;
            tail_q   <= grant_b_q ? bus.b_tail   : bus.r_tail;
            last_b_q <= grant_b_q;
            // The header can leave straight from the capture edge when the
            // VC is open; this keeps the request-to-header latency at two.
            if (vc_open) begin
              noc_data_q <= grant_b_q ? bus.b_header : bus.r_header;
              is_valid_q <= 1'b1;
              state_q    <= ST_TAIL;
            end else begin
              state_q    <= ST_HEAD;
            end
          end else begin
            // Source withdrew: drop the grant, keep the round-robin history.
            state_q  <= ST_IDLE;
            vc_sel_q <= '0;
            busy_q   <= 1'b0;
          end
        end

        ST_HEAD: begin
          if (vc_open) begin
            noc_data_q <= head_q;
            is_valid_q <= 1'b1;
            state_q    <= ST_TAIL;
          end
        end

        ST_TAIL: begin
          if (vc_open) begin
            noc_data_q <= tail_q;
            is_valid_q <= 1'b1;
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rready   = rready_q;
  assign bus.bready   = bready_q;
  assign bus.noc_data = noc_data_q;
  assign bus.is_valid = is_valid_q;
  assign bus.vc_sel   = vc_sel_q;
  assign bus.busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sna_resp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sna_resp_arbiter
// Purpose  : Self-checking bench for sna_resp_arbiter. A negedge monitor keeps
//            a packet-level reference (round-robin owner, expected flit queue
//            with the VC each packet was locked to) and checks every cycle;
//            directed sequences check exact latency and reset behaviour, then
//            randomized sources exercise arbitration and flow control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sna_resp_arbiter;

  localparam int FW = 37;
  localparam int NV = 8;

  typedef logic [2*FW-1:0] pkt_t;   // {header, tail}

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  sna_resp_arbiter_if #(.FLIT_W(FW), .NUM_VC(NV)) bus ();

  sna_resp_arbiter #(.FLIT_W(FW), .NUM_VC(NV)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] rnd_flit();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[FW-1:0];
  endfunction

  function automatic logic [NV-1:0] rnd8();
    logic [31:0] t;
    t = $urandom;
    return t[NV-1:0];
  endfunction

  // ---------------------------------------------------------------- model
  logic [FW-1:0] exp_data[$];
  logic [NV-1:0] exp_vc[$];
  logic          grant_log[$];   // every ready pulse: 0 = R, 1 = B
  logic          lg_b_m   = 1'b1;
  int            flit_cnt = 0;

  logic          p_rstn  = 1'b0;
  logic          p_rv    = 1'b0;
  logic          p_bv    = 1'b0;
  logic          p_rdy   = 1'b0;
  logic [NV-1:0] p_alloc = '0;
  logic [NV-1:0] p_onoff = '0;

  always @(negedge clock) begin
    logic          rdy_any;
    logic          gb;
    logic          exp_b;
    logic [NV-1:0] fvc;
    logic [NV-1:0] lsb;
    rdy_any = bus.rready | bus.bready;
    if (!p_rstn) begin
      check_eq("reset_outputs",
               {bus.rready, bus.bready, bus.is_valid, bus.busy, bus.vc_sel, bus.noc_data}, 64'd0);
    end else begin
      if (bus.is_valid) begin
        flit_cnt++;
        if (exp_data.size() == 0) begin
          check_eq("unexpected_flit", 1, 0);
        end else begin
          check_eq("flit_data", bus.noc_data, exp_data.pop_front());
          fvc = exp_vc.pop_front();
          check_eq("flit_vc", bus.vc_sel, fvc);
          check_eq("flit_onoff_gate", |(p_onoff & fvc), 1);
        end
      end
      if (rdy_any) begin
        check_eq("one_ready", bus.rready & bus.bready, 0);
        check_eq("ready_pulse", p_rdy, 0);
        if (!(p_rv || p_bv) || p_alloc == '0) begin
          check_eq("ready_without_request", 1, 0);
        end else begin
          exp_b = p_bv && (!p_rv || !lg_b_m);
          check_eq("winner", bus.bready, exp_b);
          lsb = p_alloc & (~p_alloc + 1'b1);
          check_eq("vc_lock", bus.vc_sel, lsb);
        end
        gb = bus.bready;
        grant_log.push_back(gb);
        if (gb ? bus.bvalid : bus.rvalid) begin
          exp_data.push_back(gb ? bus.b_header : bus.r_header);
          exp_data.push_back(gb ? bus.b_tail   : bus.r_tail);
          exp_vc.push_back(bus.vc_sel);
          exp_vc.push_back(bus.vc_sel);
          lg_b_m = gb;
        end
      end else if (!bus.is_valid) begin
        check_eq("idle_vc_sel", bus.vc_sel, (exp_vc.size() != 0) ? exp_vc[0] : '0);
      end
      check_eq("busy", bus.busy, rdy_any || (exp_data.size() != 0));
    end
    if (!resetn) begin
      exp_data.delete();
      exp_vc.delete();
      lg_b_m = 1'b1;
    end
    p_rstn  = resetn;
    p_rv    = bus.rvalid;
    p_bv    = bus.bvalid;
    p_rdy   = rdy_any;
    p_alloc = bus.is_allocatable;
    p_onoff = bus.is_on_off;
  end

  // -------------------------------------------------------------- sources
  pkt_t rq[$];
  pkt_t bq[$];
  int   r_gap = 0, b_gap = 0, r_wait = 0, b_wait = 0;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic present();
    if (rq.size() != 0 && r_gap == 0) begin
      bus.rvalid = 1'b1;
      {bus.r_header, bus.r_tail} = rq[0];
    end else begin
      bus.rvalid = 1'b0;
      bus.r_header = rnd_flit();
      bus.r_tail   = rnd_flit();
      if (r_gap > 0) r_gap--;
    end
    if (bq.size() != 0 && b_gap == 0) begin
      bus.bvalid = 1'b1;
      {bus.b_header, bus.b_tail} = bq[0];
    end else begin
      bus.bvalid = 1'b0;
      bus.b_header = rnd_flit();
      bus.b_tail   = rnd_flit();
      if (b_gap > 0) b_gap--;
    end
  endtask

  task automatic run_src(input int ncyc, input bit rnd);
    logic sr, sb;
    for (int c = 0; c < ncyc; c++) begin
      smp();
      sr = bus.rready;
      sb = bus.bready;
      cyc();
      if (sr && bus.rvalid) begin
        rq.delete(0);
        r_gap  = rnd ? int'($urandom_range(0, 3)) : 0;
        r_wait = 0;
      end else if (bus.rvalid) begin
        r_wait++;
        if (r_wait == 300) check_eq("r_starved", 1, 0);
      end
      if (sb && bus.bvalid) begin
        bq.delete(0);
        b_gap  = rnd ? int'($urandom_range(0, 3)) : 0;
        b_wait = 0;
      end else if (bus.bvalid) begin
        b_wait++;
        if (b_wait == 300) check_eq("b_starved", 1, 0);
      end
      present();
      if (rnd) begin
        bus.is_allocatable = ($urandom_range(0, 9) == 0) ? '0 : rnd8();
        bus.is_on_off      = ($urandom_range(0, 2) == 0) ? rnd8() : '1;
      end
    end
  endtask

  task automatic idle_inputs();
    bus.rvalid = 1'b0;
    bus.bvalid = 1'b0;
    bus.r_header = rnd_flit();
    bus.r_tail   = rnd_flit();
    bus.b_header = rnd_flit();
    bus.b_tail   = rnd_flit();
    bus.is_allocatable = '1;
    bus.is_on_off      = '1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    rq.delete();
    bq.delete();
    r_gap = 0; b_gap = 0; r_wait = 0; b_wait = 0;
    repeat (3) cyc();
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    pkt_t p;
    int   fc0;

    do_reset();
    smp();
    check_eq("reset_state",
             {bus.rready, bus.bready, bus.is_valid, bus.busy, bus.vc_sel, bus.noc_data}, 64'd0);

    // Minimum latency, requested on the first edge after release.
    cyc();
    resetn = 1'b1;
    bus.rvalid = 1'b1;
    bus.r_header = 37'h1_0000_00AA;
    bus.r_tail   = 37'h0_0000_00BB;
    bus.is_allocatable = 8'h0C;
    bus.is_on_off      = 8'hFF;
    smp(); check_eq("lat_c0_rready", bus.rready, 0);
    cyc(); smp();
    check_eq("lat_c1_rready", bus.rready, 1);
    check_eq("lat_c1_vc", bus.vc_sel, 8'h04);
    cyc(); bus.rvalid = 1'b0; bus.r_header = rnd_flit(); bus.r_tail = rnd_flit();
    smp();
    check_eq("lat_c2_valid", bus.is_valid, 1);
    check_eq("lat_c2_head", bus.noc_data, 37'h1_0000_00AA);
    cyc(); smp();
    check_eq("lat_c3_valid", bus.is_valid, 1);
    check_eq("lat_c3_tail", bus.noc_data, 37'h0_0000_00BB);
    cyc(); smp();
    check_eq("lat_c4_idle", {bus.is_valid, bus.vc_sel}, 0);

    // Both channels held valid: strict alternation starting with R.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rq.push_back({rnd_flit(), rnd_flit()});
      bq.push_back({rnd_flit(), rnd_flit()});
    end
    grant_log.delete();
    resetn = 1'b1;
    run_src(24, 1'b0);
    check_eq("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq("rr_order", grant_log[i], i % 2);

    // On/off closed for five cycles after ACCEPT; allocatable churns.
    do_reset();
    p = {rnd_flit(), rnd_flit()};
    resetn = 1'b1;
    bus.rvalid = 1'b1;
    {bus.r_header, bus.r_tail} = p;
    bus.is_allocatable = 8'h01;
    bus.is_on_off      = 8'h00;
    cyc();
    fc0 = flit_cnt;
    for (int k = 0; k < 5; k++) begin
      cyc();
      bus.rvalid = 1'b0;
      bus.r_header = rnd_flit();
      bus.r_tail   = rnd_flit();
      bus.is_allocatable = rnd8();
    end
    cyc();
    bus.is_on_off = 8'h01;
    check_eq("stall_no_flit", flit_cnt - fc0, 0);
    smp(); check_eq("stall_c7_valid", bus.is_valid, 0);
    cyc(); smp();
    check_eq("stall_head_valid", bus.is_valid, 1);
    check_eq("stall_head", bus.noc_data, p[2*FW-1:FW]);
    cyc(); smp();
    check_eq("stall_tail_valid", bus.is_valid, 1);
    check_eq("stall_tail", bus.noc_data, p[FW-1:0]);
    repeat (3) cyc();
    check_eq("stall_flit_count", flit_cnt - fc0, 2);

    // No free VC for four cycles, then only VC 7.
    do_reset();
    resetn = 1'b1;
    bus.bvalid = 1'b1;
    {bus.b_header, bus.b_tail} = {rnd_flit(), rnd_flit()};
    bus.is_allocatable = 8'h00;
    for (int k = 0; k < 4; k++) begin
      smp(); check_eq("noalloc_bready", bus.bready, 0);
      cyc();
    end
    bus.is_allocatable = 8'h80;
    smp(); check_eq("alloc_c4_bready", bus.bready, 0);
    cyc(); smp();
    check_eq("alloc_bready", bus.bready, 1);
    check_eq("alloc_vc", bus.vc_sel, 8'h80);
    cyc(); bus.bvalid = 1'b0;
    repeat (4) cyc();

    // Reset right after the header: no tail, then a clean packet.
    do_reset();
    p = {rnd_flit(), rnd_flit()};
    resetn = 1'b1;
    bus.rvalid = 1'b1;
    {bus.r_header, bus.r_tail} = p;
    cyc();
    cyc();
    bus.rvalid = 1'b0;
    resetn = 1'b0;
    smp();
    check_eq("rstmid_head", {bus.is_valid, bus.noc_data}, {1'b1, p[2*FW-1:FW]});
    cyc(); smp();
    check_eq("rstmid_outputs",
             {bus.rready, bus.bready, bus.is_valid, bus.busy, bus.vc_sel, bus.noc_data}, 64'd0);
    fc0 = flit_cnt;
    cyc();
    resetn = 1'b1;
    bus.rvalid = 1'b1;
    {bus.r_header, bus.r_tail} = {rnd_flit(), rnd_flit()};
    cyc();
    cyc();
    bus.rvalid = 1'b0;
    repeat (4) cyc();
    check_eq("rstmid_new_packet", flit_cnt - fc0, 2);

    // Granted source withdraws during ACCEPT.
    do_reset();
    resetn = 1'b1;
    bus.rvalid = 1'b1;
    cyc();
    bus.rvalid = 1'b0;
    smp(); check_eq("drop_rready", bus.rready, 1);
    cyc(); smp();
    check_eq("drop_idle", {bus.is_valid, bus.busy, bus.vc_sel}, 0);
    fc0 = flit_cnt;
    repeat (3) cyc();
    check_eq("drop_no_flit", flit_cnt - fc0, 0);
    grant_log.delete();
    rq.push_back({rnd_flit(), rnd_flit()});
    bq.push_back({rnd_flit(), rnd_flit()});
    run_src(14, 1'b0);
    check_eq("drop_tie_count", grant_log.size(), 2);
    if (grant_log.size() != 0) check_eq("drop_tie_r", grant_log[0], 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      rq.push_back({rnd_flit(), rnd_flit()});
      bq.push_back({rnd_flit(), rnd_flit()});
    end
    resetn = 1'b1;
    run_src(1500, 1'b1);
    bus.is_allocatable = '1;
    bus.is_on_off      = '1;
    for (int k = 0; k < 60 && (rq.size() + bq.size() + exp_data.size()) != 0; k++)
      run_src(10, 1'b0);
    check_eq("drain", rq.size() + bq.size() + exp_data.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
